// File: rtl/riscv_hazard_scoreboard.sv
// Hazard/forwarding scoreboard for the 5-stage RV32I pipeline: shadow EX/MEM/WB register usage,
// stall/flush/forward generation; optional perf counters under HAZARD_PERF_COUNTERS_EN.
module riscv_hazard_scoreboard #(
    parameter int NUM_REGS        = 32,
    parameter int REG_ADDR_W      = $clog2(NUM_REGS),
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_rs1_used,
    input  logic                  i_id_rs2_used,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_reg_write,
    input  logic                  i_id_is_load,
    input  logic                  i_branch_taken,
    input  logic                  i_jump_taken,
    input  logic                  i_hold,
    output logic                  o_stall,
    output logic                  o_flush,
    output logic [1:0]            o_fwd_a,
    output logic [1:0]            o_fwd_b,
    output logic [CNT_WIDTH-1:0]  o_stall_count,
    output logic [CNT_WIDTH-1:0]  o_flush_count
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  rs1_used;
        logic                  rs2_used;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t ex_q, mem_q, wb_q, ex_d;
    logic   redirect_s, hz_ex_s, hz_mem_s, hz_s;
    logic   unused_fields_s;

    function automatic logic writes_reg(entry_t e, logic [REG_ADDR_W-1:0] r);
        return e.valid & e.reg_write & (e.rd == r) & (r != {REG_ADDR_W{1'b0}});
    endfunction

    // A load still in MEM cannot forward, so it falls through to the WB check.
    function automatic logic [1:0] fwd_sel(logic used, logic [REG_ADDR_W-1:0] r,
                                           entry_t ex, entry_t mem, entry_t wb);
        logic [1:0] sel;
        if (!(ex.valid & used)) begin
            sel = 2'b00;
        end else if (writes_reg(mem, r) & !mem.is_load) begin
            sel = 2'b01;
        end else if (writes_reg(wb, r)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection, control outputs and next EX entry.
    always_comb begin
        redirect_s = i_branch_taken | i_jump_taken;
        hz_ex_s    = ex_q.is_load &
                     ((i_id_rs1_used & writes_reg(ex_q, i_id_rs1)) |
                      (i_id_rs2_used & writes_reg(ex_q, i_id_rs2)));
        if (LOAD_USE_STALLS == 2) begin
            hz_mem_s = mem_q.is_load &
                       ((i_id_rs1_used & writes_reg(mem_q, i_id_rs1)) |
                        (i_id_rs2_used & writes_reg(mem_q, i_id_rs2)));
        end else begin
            hz_mem_s = 1'b0;
        end
        hz_s    = i_id_valid & (hz_ex_s | hz_mem_s);
        o_flush = redirect_s & !i_hold;
        o_stall = i_hold | (hz_s & !redirect_s);
        o_fwd_a = fwd_sel(ex_q.rs1_used, ex_q.rs1, ex_q, mem_q, wb_q);
        o_fwd_b = fwd_sel(ex_q.rs2_used, ex_q.rs2, ex_q, mem_q, wb_q);
        ex_d    = {ENTRY_W{1'b0}};
        if (redirect_s | hz_s) begin
            ex_d = {ENTRY_W{1'b0}};
        end else begin
            ex_d.valid     = i_id_valid;
            ex_d.rd        = i_id_rd;
            ex_d.reg_write = i_id_reg_write;
            ex_d.is_load   = i_id_is_load;
            ex_d.rs1       = i_id_rs1;
            ex_d.rs2       = i_id_rs2;
            ex_d.rs1_used  = i_id_rs1_used;
            ex_d.rs2_used  = i_id_rs2_used;
        end
    end

    // Shadow pipeline advance; everything freezes while held.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_q  <= {ENTRY_W{1'b0}};
            mem_q <= {ENTRY_W{1'b0}};
            wb_q  <= {ENTRY_W{1'b0}};
        end else if (!i_hold) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_d;
        end
    end

    assign unused_fields_s = ^{mem_q.rs1, mem_q.rs2, mem_q.rs1_used, mem_q.rs2_used,
                               wb_q.rs1, wb_q.rs2, wb_q.rs1_used, wb_q.rs2_used, wb_q.is_load};

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Saturating hazard counters; held stall cycles are not charged.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt_q <= {CNT_WIDTH{1'b0}};
            flush_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            if (o_stall && !i_hold && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (o_flush && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign o_stall_count = stall_cnt_q;
    assign o_flush_count = flush_cnt_q;
`else
    assign o_stall_count = {CNT_WIDTH{1'b0}};
    assign o_flush_count = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// Random-stimulus bench: two scoreboards (1- and 2-cycle load-use penalty) checked each cycle
// against a stage-list reference model built from the hazard and forwarding rules.
module tb_riscv_hazard_scoreboard;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, u1, u2, we, ld, br, jp, hold;
    logic [4:0] rs1, rs2, rd;

    logic        stall0, flush0, stall1, flush1;
    logic [1:0]  fa0, fb0, fa1, fb1;
    logic [31:0] sc0, fc0;
    logic [3:0]  sc1, fc1;

    riscv_hazard_scoreboard #(.LOAD_USE_STALLS(1), .CNT_WIDTH(32)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
        .i_id_rs1_used(u1), .i_id_rs2_used(u2), .i_id_rd(rd), .i_id_reg_write(we),
        .i_id_is_load(ld), .i_branch_taken(br), .i_jump_taken(jp), .i_hold(hold),
        .o_stall(stall0), .o_flush(flush0), .o_fwd_a(fa0), .o_fwd_b(fb0),
        .o_stall_count(sc0), .o_flush_count(fc0));

    riscv_hazard_scoreboard #(.LOAD_USE_STALLS(2), .CNT_WIDTH(4)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
        .i_id_rs1_used(u1), .i_id_rs2_used(u2), .i_id_rd(rd), .i_id_reg_write(we),
        .i_id_is_load(ld), .i_branch_taken(br), .i_jump_taken(jp), .i_hold(hold),
        .o_stall(stall1), .o_flush(flush1), .o_fwd_a(fa1), .o_fwd_b(fb1),
        .o_stall_count(sc1), .o_flush_count(fc1));

    typedef struct {
        bit v; bit wr; bit ld; int rd; int rs1; int rs2; bit u1; bit u2;
    } instr_t;

    // stage[k][0] is the instruction in EX, [1] in MEM, [2] in WB
    instr_t stage [2][3];
    longint n_stall [2];
    longint n_flush [2];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit produces(instr_t i, int r);
        return i.v && i.wr && (i.rd == r) && (r != 0);
    endfunction

    // Load in any of the first k+1 stages that feeds a used ID source
    function automatic bit load_use(int k);
        bit h = 0;
        if (id_valid) begin
            for (int d = 0; d <= k; d++) begin
                if (stage[k][d].ld && ((u1 && produces(stage[k][d], int'(rs1))) ||
                                       (u2 && produces(stage[k][d], int'(rs2)))))
                    h = 1;
            end
        end
        return h;
    endfunction

    function automatic int fwd_of(int k, bit used, int r);
        if (!stage[k][0].v || !used) return 0;
        if (produces(stage[k][1], r) && !stage[k][1].ld) return 1;
        if (produces(stage[k][2], r)) return 2;
        return 0;
    endfunction

    function automatic longint sat(longint v, longint mx);
        return (v > mx) ? mx : v;
    endfunction

    initial begin
        instr_t blank;
        instr_t idi;
        bit redir, hz, e_stall, e_flush;
        longint mx;
        blank = '{default: 0};
        for (int k = 0; k < 2; k++) begin
            for (int d = 0; d < 3; d++) stage[k][d] = blank;
            n_stall[k] = 0;
            n_flush[k] = 0;
        end
        rst = 1'b1; id_valid = 1'b0; u1 = 1'b0; u2 = 1'b0; we = 1'b0; ld = 1'b0;
        br = 1'b0; jp = 1'b0; hold = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        @(posedge clk); #1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc < 2) begin
                rst = 1'b1; id_valid = 1'b0; u1 = 1'b0; u2 = 1'b0; we = 1'b0; ld = 1'b0;
                br = 1'b0; jp = 1'b0; hold = 1'b0;
            end else begin
                rst      = ($urandom_range(0, 199) == 0);
                id_valid = ($urandom_range(0, 99) < 85);
                rs1      = 5'($urandom_range(0, 3));
                rs2      = 5'($urandom_range(0, 3));
                rd       = 5'($urandom_range(0, 3));
                u1       = ($urandom_range(0, 99) < 80);
                u2       = ($urandom_range(0, 99) < 60);
                we       = ($urandom_range(0, 99) < 75);
                ld       = ($urandom_range(0, 99) < 35);
                br       = ($urandom_range(0, 99) < 6);
                jp       = ($urandom_range(0, 99) < 3);
                hold     = ($urandom_range(0, 99) < 12);
            end
            @(negedge clk);
            redir = br || jp;
            for (int k = 0; k < 2; k++) begin
                hz      = load_use(k);
                e_flush = redir && !hold;
                e_stall = hold || (hz && !redir);
                mx      = (k == 0) ? 64'hFFFF_FFFF : 64'd15;
                check_eq($sformatf("stall%0d", k), 32'(k == 0 ? stall0 : stall1), 32'(e_stall));
                check_eq($sformatf("flush%0d", k), 32'(k == 0 ? flush0 : flush1), 32'(e_flush));
                check_eq($sformatf("fwd_a%0d", k), 32'(k == 0 ? fa0 : fa1),
                         32'(fwd_of(k, stage[k][0].u1, stage[k][0].rs1)));
                check_eq($sformatf("fwd_b%0d", k), 32'(k == 0 ? fb0 : fb1),
                         32'(fwd_of(k, stage[k][0].u2, stage[k][0].rs2)));
`ifdef HAZARD_PERF_COUNTERS_EN
                check_eq($sformatf("stall_cnt%0d", k), (k == 0) ? sc0 : 32'(sc1),
                         32'(sat(n_stall[k], mx)));
                check_eq($sformatf("flush_cnt%0d", k), (k == 0) ? fc0 : 32'(fc1),
                         32'(sat(n_flush[k], mx)));
`else
                check_eq($sformatf("stall_cnt%0d", k), (k == 0) ? sc0 : 32'(sc1), 32'd0);
                check_eq($sformatf("flush_cnt%0d", k), (k == 0) ? fc0 : 32'(fc1), 32'd0);
`endif
                // advance the reference to the state after the coming edge
                if (rst) begin
                    for (int d = 0; d < 3; d++) stage[k][d] = blank;
                    n_stall[k] = 0;
                    n_flush[k] = 0;
                end else begin
                    if (e_stall && !hold) n_stall[k]++;
                    if (e_flush) n_flush[k]++;
                    if (!hold) begin
                        idi = '{v: id_valid, wr: we, ld: ld, rd: int'(rd), rs1: int'(rs1),
                                rs2: int'(rs2), u1: u1, u2: u2};
                        stage[k][2] = stage[k][1];
                        stage[k][1] = stage[k][0];
                        stage[k][0] = (redir || hz) ? blank : idi;
                    end
                end
            end
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
